// File: rtl/cube_result_buffer_if.sv
// Stream interface between cubic_poly and its result buffer: an unthrottled input
// (cube_in/cube_valid) and a valid/ready output carrying the FIFO head.
interface cube_result_buffer_if #(
   parameter int DW = 9
);
   // out_data is a transfer only in a cycle where out_valid and out_ready are both
   // high. out_valid does not depend on out_ready. cube_valid has no ready signal.
   logic [DW-1:0] cube_in;
   logic          cube_valid;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;

   modport master (
      output cube_in, cube_valid, out_ready,
      input  out_data, out_valid
   );

   modport slave (
      input  cube_in, cube_valid, out_ready,
      output out_data, out_valid
   );
endinterface

// File: rtl/cube_result_buffer.sv
// First-word-fall-through FIFO for cubic_poly results. It drops and counts samples
// that arrive while the FIFO is full, and it keeps a saturating sum of accepted samples.
module cube_result_buffer #(
   parameter int DW    = 9,
   parameter int DEPTH = 4,
   parameter int SUM_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   cube_result_buffer_if.slave      bus,
   output logic [$clog2(DEPTH):0]   count,
   output logic [SUM_W-1:0]         sum_out,
   output logic                     sum_sat,
   output logic [7:0]               drop_cnt,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
   localparam logic [SUM_W:0]   SUM_MAX  = {1'b0, {SUM_W{1'b1}}};

   logic [DW-1:0]    mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             push;
   logic             pop;
   logic             drop;
   logic [SUM_W:0]   sum_wide;

   assign full          = (count == FULL_CNT);
   assign bus.out_valid = (count != '0);
   assign pop           = bus.out_valid & bus.out_ready;
   // A full FIFO still accepts a sample when the head leaves in the same cycle.
   assign push          = bus.cube_valid & (~full | pop);
   assign drop          = bus.cube_valid & full & ~pop;
   assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
   assign sum_wide      = {1'b0, sum_out} + {{(SUM_W+1-DW){1'b0}}, bus.cube_in};

   // Storage needs no reset; out_data is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem[wr_ptr] <= bus.cube_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)      count <= count + CNT_ONE;
         else if (pop && !push) count <= count - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_out  <= '0;
         sum_sat  <= 1'b0;
         drop_cnt <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         sum_out  <= '0;
         sum_sat  <= 1'b0;
         drop_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            if (sum_wide >= SUM_MAX) begin
               sum_out <= SUM_MAX[SUM_W-1:0];
               sum_sat <= 1'b1;
            end else begin
               sum_out <= sum_wide[SUM_W-1:0];
            end
         end
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_cube_result_buffer.sv
// Random and directed stimulus for cube_result_buffer. The bench checks the design against
// a queue-based reference model. Two instances differ only in SUM_W (16 and 10).
module tb_cube_result_buffer;
   localparam int DW    = 9;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic [DW-1:0] cube_in = '0;
   logic          cube_valid = 1'b0;
   logic          out_ready = 1'b0;

   logic [CW-1:0] count_a, count_b;
   logic [15:0]   sum_a;
   logic [9:0]    sum_b;
   logic          sat_a, sat_b, ovf_a, ovf_b;
   logic [7:0]    drop_a, drop_b;

   cube_result_buffer_if #(.DW(DW)) bus_a ();
   cube_result_buffer_if #(.DW(DW)) bus_b ();

   assign bus_a.cube_in    = cube_in;
   assign bus_a.cube_valid = cube_valid;
   assign bus_a.out_ready  = out_ready;
   assign bus_b.cube_in    = cube_in;
   assign bus_b.cube_valid = cube_valid;
   assign bus_b.out_ready  = out_ready;

   cube_result_buffer #(.DW(DW), .DEPTH(DEPTH), .SUM_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_a),
      .count(count_a), .sum_out(sum_a), .sum_sat(sat_a),
      .drop_cnt(drop_a), .overflow(ovf_a)
   );

   cube_result_buffer #(.DW(DW), .DEPTH(DEPTH), .SUM_W(10)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_b),
      .count(count_b), .sum_out(sum_b), .sum_sat(sat_b),
      .drop_cnt(drop_b), .overflow(ovf_b)
   );

   // clock/reset
   always #5 clk = ~clk;

   // reference model
   int            ref_q[$];
   logic [DW-1:0] exp_q[$];
   int            sum16 = 0;
   int            sum10 = 0;
   bit            sat16 = 1'b0;
   bit            sat10 = 1'b0;
   int            drops = 0;
   bit            ovf = 1'b0;
   int            vectors = 0;
   int            miscompares = 0;

   task automatic model_reset();
      ref_q.delete();
      exp_q.delete();
      sum16 = 0;
      sum10 = 0;
      sat16 = 1'b0;
      sat10 = 1'b0;
      drops = 0;
      ovf   = 1'b0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge rst_n) model_reset();

   always @(posedge clk) begin : model_step
      bit do_pop;
      bit do_push;
      if (!rst_n || clear) begin
         model_reset();
      end else begin
         do_pop  = (ref_q.size() != 0) && out_ready;
         do_push = cube_valid && ((ref_q.size() < DEPTH) || do_pop);
         if (do_pop) void'(ref_q.pop_front());
         if (do_push) begin
            ref_q.push_back(int'(cube_in));
            exp_q.push_back(cube_in);
            sum16 = (sum16 + int'(cube_in) > 65535) ? 65535 : sum16 + int'(cube_in);
            sum10 = (sum10 + int'(cube_in) > 1023) ? 1023 : sum10 + int'(cube_in);
            if (sum16 == 65535) sat16 = 1'b1;
            if (sum10 == 1023)  sat10 = 1'b1;
         end else if (cube_valid) begin
            drops = (drops < 255) ? drops + 1 : 255;
            ovf   = 1'b1;
         end
      end
   end

   // monitor / scoreboard
   always @(negedge clk) begin : monitor
      logic [DW-1:0] exp;
      check("out_valid_a", bus_a.out_valid, ref_q.size() != 0);
      check("out_valid_b", bus_b.out_valid, ref_q.size() != 0);
      check("count_a", count_a, ref_q.size());
      check("count_b", count_b, ref_q.size());
      if (bus_a.out_valid && bus_a.out_ready) begin
         if (exp_q.size() == 0) begin
            check("pop_without_expected", 1, 0);
         end else begin
            exp = exp_q.pop_front();
            check("out_data_a", bus_a.out_data, exp);
            check("out_data_b", bus_b.out_data, exp);
         end
      end else if (!bus_a.out_valid) begin
         check("out_data_idle", bus_a.out_data, 0);
      end
      check("sum_a", sum_a, sum16);
      check("sum_b", sum_b, sum10);
      check("sat_a", sat_a, sat16);
      check("sat_b", sat_b, sat10);
      check("drop_a", drop_a, drops);
      check("drop_b", drop_b, drops);
      check("overflow_a", ovf_a, ovf);
      check("overflow_b", ovf_b, ovf);
   end

   // driver
   task automatic step(input bit v, input int d, input bit r, input bit c);
      cube_valid = v;
      cube_in    = DW'(d);
      out_ready  = r;
      clear      = c;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1, 1'b0);
   endtask

   initial begin
      int ord_vals[4];
      ord_vals = '{64, 1, 8, 343};

      repeat (2) @(posedge clk);
      #1;
      check("reset_count", count_a, 0);
      check("reset_valid", bus_a.out_valid, 0);
      rst_n = 1'b1;

      // ordering
      for (int i = 0; i < 4; i++) step(1'b1, ord_vals[i], 1'b0, 1'b0);
      check("order_count_full", count_a, 4);
      drain(5);

      // overflow and drop-counter saturation
      for (int i = 0; i < 5; i++) step(1'b1, 10 * (i + 1), 1'b0, 1'b0);
      check("ovf_sum_first4", sum_a, sum16);
      check("ovf_drop_one", drop_a, 1);
      for (int i = 0; i < 300; i++) step(1'b1, $urandom_range(0, 511), 1'b0, 1'b0);
      check("drop_saturated", drop_a, 255);
      drain(5);

      // full with simultaneous push and pop
      for (int i = 0; i < 4; i++) step(1'b1, i + 1, 1'b0, 1'b0);
      step(1'b1, 27, 1'b1, 1'b0);
      check("full_pushpop_count", count_a, 4);
      drain(5);

      // saturation on the narrow-sum instance
      step(1'b0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 343, 1'b1, 1'b0);
      step(1'b1, 0, 1'b1, 1'b0);
      check("sat_sum_b", sum_b, 1023);
      check("sat_flag_b", sat_b, 1);
      drain(3);

      // clear with a sample present
      step(1'b1, 5, 1'b0, 1'b0);
      step(1'b1, 6, 1'b0, 1'b0);
      step(1'b1, 99, 1'b0, 1'b1);
      check("clear_count", count_a, 0);
      check("clear_sum", sum_a, 0);
      drain(3);

      // asynchronous reset pulse between edges
      step(1'b1, 7, 1'b0, 1'b0);
      step(1'b1, 9, 1'b0, 1'b0);
      cube_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_count", count_a, 0);
      check("async_rst_valid", bus_a.out_valid, 0);
      check("async_rst_sum", sum_a, 0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 11, 1'b0, 1'b0);
      check("post_rst_push", count_a, 1);
      drain(3);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 511),
              $urandom_range(0, 2) == 0, $urandom_range(0, 63) == 0);
      end
      drain(6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
